row_cache_sync: RTL and testbench

Tag-table controller that maps DRAM row addresses onto a small on-chip row buffer of 2^CHWIDTH entries, for one emulated bank. It sits between the bank FSM (ACT/RD/WR/PR commands) and the host/backing-memory port. Compared with the previous generation it adds:
- invalid-first replacement;
- explicit req/ack handshakes for write-back and fill;
- a full-buffer flush operation.

---
 rtl/row_cache_sync_if.sv | 38 +++
 rtl/row_cache_sync.sv | 212 +++++++++++++++++++++
 tb/tb_row_cache_sync.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_cache_sync_if.sv
// Bank-command, write-back/fill handshake and status bundle of the row cache controller.
// The bank FSM/host side uses master; the controller uses slave.
interface row_cache_sync_if #(
    parameter int CHWIDTH   = 6,
    parameter int ADDRWIDTH = 17
);
    logic                 act;
    logic                 rd;
    logic                 wr;
    logic                 pr;
    logic                 flush;
    logic [ADDRWIDTH-1:0] row_addr;
    logic [CHWIDTH-1:0]   c_row;
    logic                 hit;
    logic                 ready;
    logic                 stall;
    logic                 flush_done;
    logic                 wb_req;
    logic                 wb_ack;
    logic [CHWIDTH-1:0]   wb_idx;
    logic [ADDRWIDTH-1:0] wb_addr;
    logic                 fill_req;
    logic                 fill_ack;
    logic [CHWIDTH-1:0]   fill_idx;
    logic [ADDRWIDTH-1:0] fill_addr;

    modport master (
        output act, rd, wr, pr, flush, row_addr, wb_ack, fill_ack,
        input  c_row, hit, ready, stall, flush_done,
               wb_req, wb_idx, wb_addr, fill_req, fill_idx, fill_addr
    );

    modport slave (
        input  act, rd, wr, pr, flush, row_addr, wb_ack, fill_ack,
        output c_row, hit, ready, stall, flush_done,
               wb_req, wb_idx, wb_addr, fill_req, fill_idx, fill_addr
    );
endinterface

// File: rtl/row_cache_sync.sv
// Tag-table controller mapping DRAM rows of one bank onto a 2^CHWIDTH-entry row buffer,
// with invalid-first/round-robin replacement, write-back/fill handshakes and a full flush.
module row_cache_sync #(
    parameter int CHWIDTH   = 6,
    parameter int ADDRWIDTH = 17
) (
    input  logic            clk,
    input  logic            rst,
    row_cache_sync_if.slave bus
);
    localparam int CHROWS = 1 << CHWIDTH;
    localparam logic [CHWIDTH-1:0] LAST = '1;

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, WB, FILL, OPEN, FSCAN, FWB} state_t;

    state_t                              state, state_n;
    logic [CHROWS-1:0]                   valid, dirty;
    logic [CHROWS-1:0][ADDRWIDTH-1:0]    rowaddr;
    logic [ADDRWIDTH-1:0]                lat_addr;
    logic [CHWIDTH-1:0]                  victim, victim_n, rr_ptr, scan, scan_n;
    logic [CHWIDTH-1:0]                  c_row_q, c_row_n, wb_idx_q, wb_idx_n, fill_idx_q, fill_idx_n;
    logic [ADDRWIDTH-1:0]                wb_addr_q, wb_addr_n, fill_addr_q, fill_addr_n;
    logic                                hit_q, hit_n, ready_q, ready_n, stall_q, stall_n;
    logic                                wb_req_q, wb_req_n, fill_req_q, fill_req_n;
    logic                                flush_done_q, flush_done_n;
    logic                                latch_addr, rr_adv, mark_dirty, clear_dirty, do_fill;
    logic                                lk_hit, inv_found;
    logic [CHWIDTH-1:0]                  lk_idx, inv_idx, victim_sel;

    // Valid rows are unique, so at most one entry can match the latched address.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = 0; i < CHROWS; i++) begin
            if (valid[i] && rowaddr[i] == lat_addr) begin
                lk_hit = 1'b1;
                lk_idx = CHWIDTH'(i);
            end
        end
    end

    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = CHROWS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                inv_found = 1'b1;
                inv_idx   = CHWIDTH'(i);
            end
        end
    end

    assign victim_sel = inv_found ? inv_idx : rr_ptr;

    always_comb begin
        state_n      = state;
        victim_n     = victim;
        scan_n       = scan;
        c_row_n      = c_row_q;
        hit_n        = 1'b0;
        ready_n      = 1'b0;
        flush_done_n = 1'b0;
        latch_addr   = 1'b0;
        rr_adv       = 1'b0;
        mark_dirty   = 1'b0;
        clear_dirty  = 1'b0;
        do_fill      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.act) begin
                    latch_addr = 1'b1;
                    state_n    = LOOKUP;
                end else if (bus.flush) begin
                    scan_n  = '0;
                    state_n = FSCAN;
                end
            end
            LOOKUP: begin
                if (lk_hit) begin
                    c_row_n = lk_idx;
                    hit_n   = 1'b1;
                    state_n = OPEN;
                end else begin
                    state_n = EVICT;
                end
            end
            EVICT: begin
                victim_n = victim_sel;
                c_row_n  = victim_sel;
                rr_adv   = !inv_found;
                state_n  = (valid[victim_sel] && dirty[victim_sel]) ? WB : FILL;
            end
            WB: begin
                if (bus.wb_ack) begin
                    clear_dirty = 1'b1;
                    state_n     = FILL;
                end
            end
            FILL: begin
                if (bus.fill_ack) begin
                    do_fill = 1'b1;
                    state_n = OPEN;
                end
            end
            OPEN: begin
                if (bus.pr) begin
                    state_n = IDLE;
                end else if (bus.act) begin
                    latch_addr = 1'b1;
                    state_n    = LOOKUP;
                end else if (bus.wr) begin
                    mark_dirty = 1'b1;
                    ready_n    = 1'b1;
                end else if (bus.rd) begin
                    ready_n = 1'b1;
                end
            end
            FSCAN: begin
                if (valid[scan] && dirty[scan]) begin
                    state_n = FWB;
                end else if (scan == LAST) begin
                    flush_done_n = 1'b1;
                    state_n      = IDLE;
                end else begin
                    scan_n = scan + 1'b1;
                end
            end
            FWB: begin
                if (bus.wb_ack) begin
                    clear_dirty = 1'b1;
                    if (scan == LAST) begin
                        flush_done_n = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        scan_n  = scan + 1'b1;
                        state_n = FSCAN;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Request outputs are registered from the next state so they rise on state entry.
        stall_n     = !(state_n == IDLE || state_n == OPEN);
        wb_req_n    = (state_n == WB) || (state_n == FWB);
        fill_req_n  = (state_n == FILL);
        wb_idx_n    = wb_req_n ? ((state_n == FWB) ? scan_n : victim_n) : '0;
        wb_addr_n   = wb_req_n ? rowaddr[wb_idx_n] : '0;
        fill_idx_n  = fill_req_n ? victim_n : '0;
        fill_addr_n = fill_req_n ? lat_addr : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            valid        <= '0;
            dirty        <= '0;
            rowaddr      <= '0;
            lat_addr     <= '0;
            victim       <= '0;
            rr_ptr       <= '0;
            scan         <= '0;
            c_row_q      <= '0;
            hit_q        <= 1'b0;
            ready_q      <= 1'b0;
            stall_q      <= 1'b0;
            flush_done_q <= 1'b0;
            wb_req_q     <= 1'b0;
            wb_idx_q     <= '0;
            wb_addr_q    <= '0;
            fill_req_q   <= 1'b0;
            fill_idx_q   <= '0;
            fill_addr_q  <= '0;
        end else begin
            state        <= state_n;
            victim       <= victim_n;
            scan         <= scan_n;
            c_row_q      <= c_row_n;
            hit_q        <= hit_n;
            ready_q      <= ready_n;
            stall_q      <= stall_n;
            flush_done_q <= flush_done_n;
            wb_req_q     <= wb_req_n;
            wb_idx_q     <= wb_idx_n;
            wb_addr_q    <= wb_addr_n;
            fill_req_q   <= fill_req_n;
            fill_idx_q   <= fill_idx_n;
            fill_addr_q  <= fill_addr_n;
            if (latch_addr) lat_addr <= bus.row_addr;
            if (rr_adv) rr_ptr <= rr_ptr + 1'b1;
            if (clear_dirty) dirty[wb_idx_q] <= 1'b0;
            if (mark_dirty) dirty[c_row_q] <= 1'b1;
            if (do_fill) begin
                valid[victim]   <= 1'b1;
                dirty[victim]   <= 1'b0;
                rowaddr[victim] <= lat_addr;
            end
        end
    end

    assign bus.c_row      = c_row_q;
    assign bus.hit        = hit_q;
    assign bus.ready      = ready_q;
    assign bus.stall      = stall_q;
    assign bus.flush_done = flush_done_q;
    assign bus.wb_req     = wb_req_q;
    assign bus.wb_idx     = wb_idx_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.fill_req   = fill_req_q;
    assign bus.fill_idx   = fill_idx_q;
    assign bus.fill_addr  = fill_addr_q;
endmodule

// File: tb/tb_row_cache_sync.sv
// Scoreboard bench for row_cache_sync: a table-level model predicts hit/wb/fill/ready/flush
// events into a queue that a negedge monitor consumes, plus directed latency checks.
module tb_row_cache_sync;
    localparam int CHWIDTH   = 6;
    localparam int ADDRWIDTH = 17;
    localparam int CHROWS    = 64;
    localparam int EV_HIT = 1, EV_WB = 2, EV_FILL = 3, EV_READY = 4, EV_FDONE = 5;

    typedef struct {
        int kind;
        int idx;
        int addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];
    logic prev_wb = 1'b0;
    logic prev_fill = 1'b0;

    bit   m_valid [CHROWS];
    bit   m_dirty [CHROWS];
    int   m_row   [CHROWS];
    int   m_rr;
    int   m_crow;
    bit   m_open;

    row_cache_sync_if #(.CHWIDTH(CHWIDTH), .ADDRWIDTH(ADDRWIDTH)) bus ();

    row_cache_sync #(.CHWIDTH(CHWIDTH), .ADDRWIDTH(ADDRWIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int idx, input int addr);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.addr = addr;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input int kind, input int idx, input int addr);
        exp_t e;
        if (sbq.size() == 0) begin
            checkOutput("unexpected_event", kind, 0);
            return;
        end
        e = sbq.pop_front();
        checkOutput("event_kind", kind, e.kind);
        if (e.kind == kind && (kind == EV_HIT || kind == EV_WB || kind == EV_FILL))
            checkOutput("event_idx", idx, e.idx);
        if (e.kind == kind && (kind == EV_WB || kind == EV_FILL))
            checkOutput("event_addr", addr, e.addr);
    endtask

    // Monitor: every visible DUT event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.hit) pop_check(EV_HIT, int'(bus.c_row), 0);
            if (bus.wb_req && !prev_wb) pop_check(EV_WB, int'(bus.wb_idx), int'(bus.wb_addr));
            if (bus.fill_req && !prev_fill) pop_check(EV_FILL, int'(bus.fill_idx), int'(bus.fill_addr));
            if (bus.ready) pop_check(EV_READY, 0, 0);
            if (bus.flush_done) pop_check(EV_FDONE, 0, 0);
        end
        prev_wb   = bus.wb_req;
        prev_fill = bus.fill_req;
    end

    task automatic model_reset;
        for (int i = 0; i < CHROWS; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_row[i]   = 0;
        end
        m_rr   = 0;
        m_crow = 0;
        m_open = 0;
    endtask

    task automatic serve(input bit is_wb, input int delay, output int waited);
        int n = 0;
        logic [31:0] i0, a0;
        while (!(is_wb ? bus.wb_req : bus.fill_req) && n < 100) begin
            tick;
            n++;
        end
        waited = n;
        if (n >= 100) begin
            checkOutput(is_wb ? "wb_req_timeout" : "fill_req_timeout", 0, 1);
            return;
        end
        i0 = is_wb ? 32'(bus.wb_idx) : 32'(bus.fill_idx);
        a0 = is_wb ? 32'(bus.wb_addr) : 32'(bus.fill_addr);
        repeat (delay) begin
            tick;
            checkOutput("req_held", is_wb ? bus.wb_req : bus.fill_req, 1);
            checkOutput("idx_stable", is_wb ? 32'(bus.wb_idx) : 32'(bus.fill_idx), i0);
            checkOutput("addr_stable", is_wb ? 32'(bus.wb_addr) : 32'(bus.fill_addr), a0);
            checkOutput("stall_held", bus.stall, 1);
            if (is_wb) checkOutput("fill_before_wb_ack", bus.fill_req, 0);
        end
        if (is_wb) bus.wb_ack = 1'b1;
        else bus.fill_ack = 1'b1;
        tick;
        bus.wb_ack   = 1'b0;
        bus.fill_ack = 1'b0;
        if (is_wb) checkOutput("wb_req_drop", bus.wb_req, 0);
        else checkOutput("fill_req_drop", bus.fill_req, 0);
    endtask

    // Activate a row: predict hit or victim from the table model, then drive and serve it.
    task automatic applyStimulus(input int addr, input int wb_delay, input int fill_delay);
        int hit_idx = -1;
        int victim = -1;
        int w;
        bit dirty_victim = 0;
        for (int i = 0; i < CHROWS; i++)
            if (m_valid[i] && m_row[i] == addr) hit_idx = i;
        if (hit_idx >= 0) begin
            push(EV_HIT, hit_idx, 0);
            m_crow = hit_idx;
        end else begin
            for (int i = 0; i < CHROWS; i++)
                if (!m_valid[i]) begin
                    victim = i;
                    break;
                end
            if (victim < 0) begin
                victim = m_rr;
                m_rr = (m_rr + 1) % CHROWS;
            end
            dirty_victim = m_valid[victim] && m_dirty[victim];
            if (dirty_victim) push(EV_WB, victim, m_row[victim]);
            push(EV_FILL, victim, addr);
            m_valid[victim] = 1;
            m_dirty[victim] = 0;
            m_row[victim]   = addr;
            m_crow          = victim;
        end
        m_open = 1;
        bus.act      = 1'b1;
        bus.row_addr = ADDRWIDTH'(addr);
        tick;
        bus.act = 1'b0;
        if (hit_idx >= 0) begin
            tick;
            checkOutput("hit_latency", bus.hit, 1);
            checkOutput("hit_stall", bus.stall, 0);
        end else begin
            if (dirty_victim) begin
                serve(1, wb_delay, w);
                checkOutput("wb_req_latency", w, 2);
                serve(0, fill_delay, w);
                checkOutput("fill_after_wb_latency", w, 0);
            end else begin
                serve(0, fill_delay, w);
                checkOutput("fill_req_latency", w, 2);
            end
            checkOutput("miss_open_stall", bus.stall, 0);
        end
        checkOutput("c_row", bus.c_row, m_crow);
    endtask

    task automatic do_col(input bit rd, input bit wr, input bit pr);
        if (pr) m_open = 0;
        else if (wr) begin
            m_dirty[m_crow] = 1;
            push(EV_READY, 0, 0);
        end else if (rd) push(EV_READY, 0, 0);
        bus.rd = rd;
        bus.wr = wr;
        bus.pr = pr;
        tick;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.pr = 1'b0;
        checkOutput("ready_pulse", bus.ready, (!pr && (rd || wr)) ? 1 : 0);
        if (pr) checkOutput("close_stall", bus.stall, 0);
    endtask

    task automatic do_flush(input int reset_on_wb, output int cycles);
        int n = 1;
        int wbs = 0;
        bit done = 0;
        for (int i = 0; i < CHROWS; i++)
            if (m_valid[i] && m_dirty[i]) begin
                push(EV_WB, i, m_row[i]);
                m_dirty[i] = 0;
            end
        push(EV_FDONE, 0, 0);
        bus.flush = 1'b1;
        tick;
        bus.flush = 1'b0;
        while (!done && n < 1000) begin
            if (bus.flush_done) done = 1;
            else if (bus.wb_req) begin
                wbs++;
                if (wbs == reset_on_wb) begin
                    @(negedge clk);
                    #1;
                    rst = 1'b1;
                    #1;
                    checkOutput("rst_wb_req_drop", bus.wb_req, 0);
                    checkOutput("rst_fill_req", bus.fill_req, 0);
                    checkOutput("rst_stall", bus.stall, 0);
                    sbq.delete();
                    model_reset();
                    tick;
                    rst = 1'b0;
                    cycles = n;
                    return;
                end
                bus.wb_ack = 1'b1;
                tick;
                bus.wb_ack = 1'b0;
                n++;
            end else begin
                tick;
                n++;
            end
        end
        checkOutput("flush_done_seen", done, 1);
        cycles = n;
    endtask

    initial begin
        int n, r, saved;
        logic [2:0] c;
        bus.act = 0; bus.rd = 0; bus.wr = 0; bus.pr = 0; bus.flush = 0;
        bus.row_addr = '0; bus.wb_ack = 0; bus.fill_ack = 0;
        model_reset();
        repeat (3) tick;
        checkOutput("rst_stall0", bus.stall, 0);
        checkOutput("rst_hit0", bus.hit, 0);
        checkOutput("rst_ready0", bus.ready, 0);
        checkOutput("rst_wb_req0", bus.wb_req, 0);
        checkOutput("rst_fill_req0", bus.fill_req, 0);
        checkOutput("rst_c_row0", bus.c_row, 0);
        checkOutput("rst_flush_done0", bus.flush_done, 0);
        rst = 1'b0;
        tick;

        do_flush(0, n);
        checkOutput("empty_flush_latency", n, CHROWS + 1);
        applyStimulus(32'h00123, 0, 1);
        do_col(0, 0, 1);
        applyStimulus(32'h00123, 0, 0);
        for (int i = 1; i < CHROWS; i++) applyStimulus(32'h1000 + i, 0, $urandom_range(0, 2));
        applyStimulus(32'h00123, 0, 0);
        do_col(0, 1, 0);
        applyStimulus(32'h2000, 10, 0);
        applyStimulus(32'h2001, 0, 0);
        do_col(1, 1, 1);
        do_flush(0, n);
        checkOutput("clean_flush_latency", n, CHROWS + 1);
        applyStimulus(32'h2001, 0, 0);
        do_col(0, 1, 0);
        do_col(1, 0, 0);
        do_col(1, 1, 0);
        do_col(0, 0, 1);

        for (int k = 0; k < 400; k++) begin
            if (m_open) begin
                r = $urandom_range(0, 3);
                if (r == 0) applyStimulus(32'h100 + $urandom_range(0, 95), $urandom_range(0, 3), $urandom_range(0, 3));
                else begin
                    c = 3'($urandom_range(1, 7));
                    do_col(c[0], c[1], c[2]);
                end
            end else begin
                r = $urandom_range(0, 9);
                if (r == 0) do_flush(0, n);
                else if (r == 1) begin
                    bus.rd = 1'b1;
                    bus.wr = 1'b1;
                    tick;
                    bus.rd = 1'b0;
                    bus.wr = 1'b0;
                    checkOutput("idle_no_ready", bus.ready, 0);
                end else applyStimulus(32'h100 + $urandom_range(0, 95), $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end

        if (m_open) do_col(0, 0, 1);
        do_flush(0, n);
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(m_row[3], 0, 0);
            do_col(0, 1, 0);
            do_col(0, 0, 1);
            applyStimulus(m_row[7], 0, 0);
            do_col(0, 1, 0);
            do_col(0, 0, 1);
            if (pass == 0) begin
                do_flush(0, n);
                applyStimulus(m_row[3], 0, 0);
                do_col(0, 0, 1);
                do_flush(0, n);
                checkOutput("post_flush_clean_latency", n, CHROWS + 1);
            end
        end
        saved = m_row[3];
        do_flush(2, n);
        tick;
        applyStimulus(saved, 0, 0);
        do_col(0, 0, 1);

        repeat (5) tick;
        checkOutput("sb_leftover", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
